// File: rtl/nf10_arp_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// nf10_arp_pkt_arbiter : packet-granular 2:1 AXI-Stream arbiter (port 0 = ARP
// replies, port 1 = bypass) with per-port forwarded-packet counters.
// Revision 1.0
// ============================================================================
module nf10_arp_pkt_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STRICT_PRIO          = 0
) (
  input  logic                               axi_aclk,
  input  logic                               axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_0_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_0_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_0_tuser,
  input  logic                               s_axis_0_tvalid,
  output logic                               s_axis_0_tready,
  input  logic                               s_axis_0_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_1_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_1_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_1_tuser,
  input  logic                               s_axis_1_tvalid,
  output logic                               s_axis_1_tready,
  input  logic                               s_axis_1_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [31:0]                        pkt_cnt_0,
  output logic [31:0]                        pkt_cnt_1
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic                              state_q, state_d;
  logic                              grant_q, grant_d;
  logic                              last_grant_q, last_grant_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  tstrb_q, tstrb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic [31:0]                       cnt0_q, cnt0_d;
  logic [31:0]                       cnt1_q, cnt1_d;
  logic                              out_adv;
  logic                              acc0;
  logic                              acc1;
  logic                              sel_last;

  // The output register may take a new beat when empty or being drained.
  assign out_adv         = !tvalid_q || m_axis_tready;
  assign s_axis_0_tready = (state_q == ST_BUSY) && !grant_q && out_adv;
  assign s_axis_1_tready = (state_q == ST_BUSY) &&  grant_q && out_adv;
  assign acc0            = s_axis_0_tvalid && s_axis_0_tready;
  assign acc1            = s_axis_1_tvalid && s_axis_1_tready;
  assign sel_last        = grant_q ? s_axis_1_tlast : s_axis_0_tlast;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_0_tvalid || s_axis_1_tvalid) begin
          if (s_axis_0_tvalid && s_axis_1_tvalid)
            grant_d = (STRICT_PRIO != 0) ? 1'b0 : !last_grant_q;
          else
            grant_d = !s_axis_0_tvalid;
          last_grant_d = grant_d;
          state_d      = ST_BUSY;
        end
      end
      default: begin
        if ((acc0 || acc1) && sel_last)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tuser_d  = tuser_q;
    if (acc0 || acc1) begin
      tvalid_d = 1'b1;
      tlast_d  = sel_last;
      tdata_d  = grant_q ? s_axis_1_tdata : s_axis_0_tdata;
      tstrb_d  = grant_q ? s_axis_1_tstrb : s_axis_0_tstrb;
      tuser_d  = grant_q ? s_axis_1_tuser : s_axis_0_tuser;
    end else if (out_adv) begin
      tvalid_d = 1'b0;
    end
  end

  // Free-running 32-bit counters: wrap naturally, never saturate.
  always_comb begin
    cnt0_d = cnt0_q + {31'd0, acc0 && s_axis_0_tlast};
    cnt1_d = cnt1_q + {31'd0, acc1 && s_axis_1_tlast};
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tstrb_q      <= '0;
      tuser_q      <= '0;
      cnt0_q       <= 32'd0;
      cnt1_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      tstrb_q      <= tstrb_d;
      tuser_q      <= tuser_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign pkt_cnt_0     = cnt0_q;
  assign pkt_cnt_1     = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_nf10_arp_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// tb_nf10_arp_pkt_arbiter : round-robin and strict-priority instances driven
// from packet queues, with a packet-level reference model and scoreboard.
// Revision 1.0
// ============================================================================
module tb_nf10_arp_pkt_arbiter;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;
  localparam int BW = DW + SW + UW + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
    logic          first;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_tdata  [2][2];
  logic [SW-1:0] s_tstrb  [2][2];
  logic [UW-1:0] s_tuser  [2][2];
  logic          s_tvalid [2][2];
  logic          s_tready [2][2];
  logic          s_tlast  [2][2];
  logic [DW-1:0] m_tdata  [2];
  logic [SW-1:0] m_tstrb  [2];
  logic [UW-1:0] m_tuser  [2];
  logic          m_tvalid [2];
  logic          m_tready [2];
  logic          m_tlast  [2];
  logic [31:0]   pkt_cnt  [2][2];

  beat_t       stim_q [2][2][$];
  beat_t       exp_q  [2][$];
  logic [31:0] mcnt   [2][2];
  bit          mlast  [2];
  int          acc_cnt [2][2];
  int          rdy_mode;
  bit          gaps_en;
  int          cyc;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  nf10_arp_pkt_arbiter #(.STRICT_PRIO(0)) u_dut_rr (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_0_tdata(s_tdata[0][0]), .s_axis_0_tstrb(s_tstrb[0][0]), .s_axis_0_tuser(s_tuser[0][0]),
    .s_axis_0_tvalid(s_tvalid[0][0]), .s_axis_0_tready(s_tready[0][0]), .s_axis_0_tlast(s_tlast[0][0]),
    .s_axis_1_tdata(s_tdata[0][1]), .s_axis_1_tstrb(s_tstrb[0][1]), .s_axis_1_tuser(s_tuser[0][1]),
    .s_axis_1_tvalid(s_tvalid[0][1]), .s_axis_1_tready(s_tready[0][1]), .s_axis_1_tlast(s_tlast[0][1]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tstrb(m_tstrb[0]), .m_axis_tuser(m_tuser[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]),
    .pkt_cnt_0(pkt_cnt[0][0]), .pkt_cnt_1(pkt_cnt[0][1])
  );

  nf10_arp_pkt_arbiter #(.STRICT_PRIO(1)) u_dut_sp (
    .axi_aclk(clk), .axi_reset(rst),
    .s_axis_0_tdata(s_tdata[1][0]), .s_axis_0_tstrb(s_tstrb[1][0]), .s_axis_0_tuser(s_tuser[1][0]),
    .s_axis_0_tvalid(s_tvalid[1][0]), .s_axis_0_tready(s_tready[1][0]), .s_axis_0_tlast(s_tlast[1][0]),
    .s_axis_1_tdata(s_tdata[1][1]), .s_axis_1_tstrb(s_tstrb[1][1]), .s_axis_1_tuser(s_tuser[1][1]),
    .s_axis_1_tvalid(s_tvalid[1][1]), .s_axis_1_tready(s_tready[1][1]), .s_axis_1_tlast(s_tlast[1][1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tstrb(m_tstrb[1]), .m_axis_tuser(m_tuser[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]),
    .pkt_cnt_0(pkt_cnt[1][0]), .pkt_cnt_1(pkt_cnt[1][1])
  );

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pk(input beat_t b);
    return {b.data, b.strb, b.user, b.last};
  endfunction

  function automatic beat_t rand_beat(input bit first, input bit last);
    beat_t b;
    for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom;
    for (int k = 0; k < UW / 32; k++) b.user[k*32 +: 32] = $urandom;
    b.strb  = $urandom;
    b.last  = last;
    b.first = first;
    return b;
  endfunction

  // Upstream sources: each packet's first beat goes out as soon as it is at
  // the head of the queue; later beats may be delayed by random gaps.
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    for (genvar gp = 0; gp < 2; gp++) begin : g_port
      initial begin
        bit    acc;
        beat_t b;
        acc = 1'b0;
        s_tvalid[gi][gp] = 1'b0;
        s_tdata[gi][gp]  = '0;
        s_tstrb[gi][gp]  = '0;
        s_tuser[gi][gp]  = '0;
        s_tlast[gi][gp]  = 1'b0;
        forever begin
          @(negedge clk);
          if (acc && stim_q[gi][gp].size() > 0) begin
            stim_q[gi][gp].delete(0);
            acc_cnt[gi][gp]++;
          end
          if (stim_q[gi][gp].size() > 0) begin
            b = stim_q[gi][gp][0];
            if (!b.first && gaps_en && $urandom_range(3) == 0) begin
              s_tvalid[gi][gp] = 1'b0;
            end else begin
              s_tvalid[gi][gp] = 1'b1;
              s_tdata[gi][gp]  = b.data;
              s_tstrb[gi][gp]  = b.strb;
              s_tuser[gi][gp]  = b.user;
              s_tlast[gi][gp]  = b.last;
            end
          end else begin
            s_tvalid[gi][gp] = 1'b0;
          end
          #4;
          acc = s_tvalid[gi][gp] && s_tready[gi][gp] && !rst;
        end
      end
    end

    // Sink and monitor: drives backpressure and scores every accepted output beat.
    initial begin
      beat_t           e;
      logic [BW-1:0]   prv;
      bit              stall;
      int              pat;
      stall = 1'b0;
      prv   = '0;
      pat   = 0;
      m_tready[gi] = 1'b0;
      forever begin
        @(negedge clk);
        case (rdy_mode)
          0:       m_tready[gi] = 1'b1;
          2:       m_tready[gi] = (pat % 4 == 0) || (pat % 4 == 3);
          default: m_tready[gi] = ($urandom_range(2) != 0);
        endcase
        pat++;
        #4;
        if (rst) begin
          stall = 1'b0;
        end else begin
          if (stall) begin
            chk($sformatf("hold_valid[%0d]", gi), BW'(m_tvalid[gi]), BW'(1));
            chk($sformatf("hold_beat[%0d]", gi),
                {m_tdata[gi], m_tstrb[gi], m_tuser[gi], m_tlast[gi]}, prv);
          end
          if (m_tvalid[gi] && !m_tready[gi])
            chk($sformatf("stall_tready[%0d]", gi),
                BW'({s_tready[gi][0], s_tready[gi][1]}), BW'(0));
          if (m_tvalid[gi] && m_tready[gi]) begin
            if (exp_q[gi].size() == 0) begin
              chk($sformatf("unexpected_beat[%0d]", gi), BW'(1), BW'(0));
            end else begin
              e = exp_q[gi].pop_front();
              chk($sformatf("out_beat[%0d]", gi),
                  {m_tdata[gi], m_tstrb[gi], m_tuser[gi], m_tlast[gi]}, pk(e));
            end
          end
          stall = m_tvalid[gi] && !m_tready[gi];
          prv   = {m_tdata[gi], m_tstrb[gi], m_tuser[gi], m_tlast[gi]};
        end
      end
    end
  end

  // Packet-level reference: at each arbitration point pick a port from which
  // ports still have packets pending, then emit that whole packet.
  task automatic model_inst(input int gi, input bit strict, input beat_t src0[$], input beat_t src1[$]);
    beat_t q0[$];
    beat_t q1[$];
    beat_t b;
    bit    g;
    q0 = src0;
    q1 = src1;
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) g = strict ? 1'b0 : !mlast[gi];
      else                                g = (q0.size() == 0);
      mlast[gi] = g;
      mcnt[gi][g] = mcnt[gi][g] + 32'd1;
      do begin
        b = g ? q1.pop_front() : q0.pop_front();
        exp_q[gi].push_back(b);
      end while (!b.last);
    end
  endtask

  task automatic load_phase(input int n0, input int n1, input int minl, input int maxl);
    beat_t p0[$];
    beat_t p1[$];
    int    len;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < (p == 0 ? n0 : n1); k++) begin
        len = $urandom_range(maxl, minl);
        for (int j = 0; j < len; j++) begin
          if (p == 0) p0.push_back(rand_beat(j == 0, j == len - 1));
          else        p1.push_back(rand_beat(j == 0, j == len - 1));
        end
      end
    end
    for (int gi = 0; gi < 2; gi++) begin
      foreach (p0[j]) stim_q[gi][0].push_back(p0[j]);
      foreach (p1[j]) stim_q[gi][1].push_back(p1[j]);
      model_inst(gi, gi == 1, p0, p1);
    end
  endtask

  task automatic flush_all();
    for (int gi = 0; gi < 2; gi++) begin
      exp_q[gi].delete();
      stim_q[gi][0].delete();
      stim_q[gi][1].delete();
    end
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
             (stim_q[0][0].size() == 0) && (stim_q[0][1].size() == 0) &&
             (stim_q[1][0].size() == 0) && (stim_q[1][1].size() == 0);
    end
    chk({nm, "_drain_timeout"}, BW'(done), BW'(1));
    if (!done) flush_all();
    repeat (2) @(posedge clk);
    #1;
    for (int gi = 0; gi < 2; gi++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("%s_pkt_cnt[%0d][%0d]", nm, gi, p), BW'(pkt_cnt[gi][p]), BW'(mcnt[gi][p]));
  endtask

  task automatic run_phase(input string nm, input int n0, input int n1, input int minl,
                           input int maxl, input bit gaps, input int mode);
    @(posedge clk); #1;
    gaps_en  = gaps;
    rdy_mode = mode;
    load_phase(n0, n1, minl, maxl);
    drain(nm);
  endtask

  task automatic check_idle_zero(input string nm);
    for (int gi = 0; gi < 2; gi++) begin
      chk($sformatf("%s_tvalid[%0d]", nm, gi), BW'(m_tvalid[gi]), BW'(0));
      chk($sformatf("%s_tready[%0d]", nm, gi), BW'({s_tready[gi][0], s_tready[gi][1]}), BW'(0));
      chk($sformatf("%s_cnt[%0d]", nm, gi), BW'({pkt_cnt[gi][0], pkt_cnt[gi][1]}), BW'(0));
    end
  endtask

  initial begin
    int base;
    bit hit;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst      = 1'b1;
    rdy_mode = 0;
    gaps_en  = 1'b0;
    for (int gi = 0; gi < 2; gi++) begin
      mlast[gi] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        mcnt[gi][p]    = 32'd0;
        acc_cnt[gi][p] = 0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    for (int gi = 0; gi < 2; gi++)
      chk($sformatf("reset_outbeat[%0d]", gi),
          {m_tdata[gi], m_tstrb[gi], m_tuser[gi], m_tlast[gi]}, BW'(0));
    rst = 1'b0;

    run_phase("p0_3beat", 1, 0, 3, 3, 1'b0, 0);
    run_phase("both_2beat", 4, 4, 2, 2, 1'b0, 0);
    for (int r = 0; r < 6; r++)
      run_phase($sformatf("rand%0d", r), $urandom_range(5), $urandom_range(5), 1, 5, 1'b1, 1);
    run_phase("single_beat", 3, 3, 1, 1, 1'b0, 1);
    run_phase("tready_1001", 1, 1, 4, 4, 1'b0, 2);

    // Counter wrap: preload both port-1 counters just below the wrap point.
    @(negedge clk);
    force u_dut_rr.cnt1_q = 32'hFFFF_FFFE;
    force u_dut_sp.cnt1_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release u_dut_rr.cnt1_q;
    release u_dut_sp.cnt1_q;
    mcnt[0][1] = 32'hFFFF_FFFE;
    mcnt[1][1] = 32'hFFFF_FFFE;
    run_phase("wrap", 0, 2, 1, 1, 1'b0, 1);

    // Reset in the middle of a 5-beat packet.
    @(posedge clk); #1;
    rdy_mode = 0;
    gaps_en  = 1'b0;
    base = acc_cnt[0][0];
    load_phase(1, 0, 5, 5);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk); #1;
      hit = (acc_cnt[0][0] > base);
    end
    chk("midpkt_wait_timeout", BW'(hit), BW'(1));
    rst = 1'b1;
    flush_all();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int gi = 0; gi < 2; gi++) begin
      mlast[gi] = 1'b1;
      mcnt[gi][0] = 32'd0;
      mcnt[gi][1] = 32'd0;
    end
    check_idle_zero("after_reset");
    run_phase("post_reset", 2, 2, 1, 4, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
